// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-input stream mux and its bench model.
package mux_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_e;

  // Round-robin successor of a channel index, wrapping at n-1.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester found searching from ptr upward, modulo N.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic [SELW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = SELW'((int'(ptr) + k) % N);
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux_nxw_stream.sv
// N-input valid/ready stream mux with registered output, fixed-index or round-robin select.
module mux_nxw_stream
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic [SELW-1:0]  r_rr_ptr;

  mux_mode_e        w_mode;
  logic             w_can_load;
  logic [N-1:0]     w_fix_gnt;
  logic [N-1:0]     w_rr_gnt;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_rr_any;
  logic [N-1:0]     w_gnt;
  logic [SELW-1:0]  w_g;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;

  assign w_mode     = mux_mode_e'(mode);
  assign w_can_load = ~r_out_valid | out_ready;

  // An out-of-range sel matches no channel, so nothing transfers and the output drains.
  always_comb begin
    w_fix_gnt = '0;
    for (int i = 0; i < N; i++) begin
      w_fix_gnt[i] = (int'(sel) == i);
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx),
    .any     (w_rr_any)
  );

  assign w_gnt    = (w_mode == MUX_RR) ? w_rr_gnt : w_fix_gnt;
  assign w_g      = (w_mode == MUX_RR) ? w_rr_idx : sel;
  assign in_ready = (rst_n && w_can_load) ? w_gnt : '0;
  assign w_xfer   = |(in_ready & in_valid);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_sel_data = w_sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: load replaces a draining beat in the same cycle; a stall holds everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_g;
      if (w_mode == MUX_RR) begin
        r_rr_ptr <= SELW'(rr_next(int'(w_g), N));
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_nxw_stream.sv
// Directed and randomized checks of mux_nxw_stream against a scoreboard and pointer model.
module tb_mux_nxw_stream;
  import mux_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [1:0]     sel = 2'd0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_ready = 1'b0;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  logic  m_valid = 1'b0;
  int    m_ptr = 0;

  always #5 clk = ~clk;

  mux_nxw_stream #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check current outputs and in_ready against the model, then advance the model.
  task automatic step();
    logic [N-1:0] eg;
    int           g;
    int           idx;
    logic         found;
    beat_t        b;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid && out_valid && sb.size() != 0) begin
      chk("out_data", out_data, sb[0].data);
      chk("out_ch", 32'(out_ch), 32'(sb[0].ch));
    end
    eg = '0;
    g = 0;
    found = 1'b0;
    if (rst_n && (!m_valid || out_ready)) begin
      if (mode == 1'b0) begin
        eg[sel] = 1'b1;
        g = int'(sel);
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && in_valid[idx]) begin
            found = 1'b1;
            eg[idx] = 1'b1;
            g = idx;
          end
        end
      end
    end
    chk("in_ready", 32'(in_ready), 32'(eg));
    chk("in_ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
    if (!rst_n) begin
      sb.delete();
      m_valid = 1'b0;
      m_ptr = 0;
    end else begin
      if (m_valid && out_ready) void'(sb.pop_front());
      if ((eg & in_valid) != '0) begin
        b.ch = 2'(g);
        b.data = in_data[g*W +: W];
        sb.push_back(b);
        m_valid = 1'b1;
        if (mode == 1'b1) m_ptr = rr_next(g, N);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    // Reset with every producer offering data.
    rst_n = 1'b0;
    in_valid = 4'b1111;
    in_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Fixed select of channel 2.
    rst_n = 1'b1;
    mode = 1'b0;
    sel = 2'd2;
    in_data = {32'h3333_3333, 32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0000};
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'h4);
    #1;
    @(negedge clk);
    m_valid = 1'b1;
    m_ptr = 0;
    begin
      beat_t b0;
      b0.ch = 2'd2;
      b0.data = 32'hFFFF_FFFF;
      sb.push_back(b0);
    end
    chk("fix_out_data", out_data, 32'hFFFF_FFFF);
    chk("fix_out_ch", 32'(out_ch), 32'd2);
    chk("fix_out_valid", 32'(out_valid), 32'd1);

    // Round-robin with all channels valid rotates 0,1,2,3.
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("rr_seq", 32'(out_ch), 32'(i % 4));
    end

    // Round-robin skips idle channels.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_skip", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rr_single", 32'(out_ch), 32'd1);
    end

    // Backpressure holds beat A, then drain and reload in one cycle.
    mode = 1'b0;
    sel = 2'd0;
    in_valid = 4'b0001;
    in_data[W-1:0] = 32'hDEAD_BEEF;
    step();
    chk("bp_load", out_data, 32'hDEAD_BEEF);
    in_data[W-1:0] = 32'h1234_5678;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", out_data, 32'hDEAD_BEEF);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_reload_data", out_data, 32'h1234_5678);
    chk("bp_reload_valid", 32'(out_valid), 32'd1);

    // Randomized traffic with a reset pulse in the middle.
    for (int c = 0; c < 2000; c++) begin
      rst_n = (c != 1000);
      mode = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst_n = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
